// File: rtl/control_unit_fsm.sv
// Multi-cycle control FSM for the Mini-SRC datapath.
// The FSM fetches, decodes and executes one instruction at a time, and
// handshakes with memory through ready/valid-style read and write requests.
module control_unit_fsm #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        in_rst_n,
  input  logic        in_run,
  input  logic [31:0] in_ir,
  input  logic        in_mem_ready,
  output logic        out_reg_clear,
  output logic [8:0]  out_bus_sel,
  output logic [8:0]  out_wr_en,
  output logic [3:0]  out_regfile_loc,
  output logic [3:0]  out_alu_opcode,
  output logic        out_inc_pc,
  output logic        out_mdr_select,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_halted,
  output logic        out_error
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Bit positions inside out_bus_sel
  localparam int BUS_RF  = 0;
  localparam int BUS_HI  = 1;
  localparam int BUS_LO  = 2;
  localparam int BUS_ZHI = 3;
  localparam int BUS_ZLO = 4;
  localparam int BUS_PC  = 5;
  localparam int BUS_MDR = 6;
  localparam int BUS_C   = 8;

  // Bit positions inside out_wr_en
  localparam int WR_RF  = 0;
  localparam int WR_HI  = 1;
  localparam int WR_LO  = 2;
  localparam int WR_Z   = 3;
  localparam int WR_PC  = 4;
  localparam int WR_MDR = 5;
  localparam int WR_IR  = 6;
  localparam int WR_Y   = 7;
  localparam int WR_MAR = 8;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_MUL = 4'd4;
  localparam logic [3:0] ALU_DIV = 4'd5;

  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_F0, S_F1, S_F2,
    S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             error_q;
  logic             set_error;

  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       ir_unused;

  assign op = in_ir[31:27];
  assign ra = in_ir[26:23];
  assign rb = in_ir[22:19];
  assign rc = in_ir[18:15];
  // The immediate field goes straight to the datapath; the FSM never looks at it.
  assign ir_unused = ^in_ir[14:0];

  logic is_alu_reg;
  logic is_imm;
  logic is_mem;
  logic is_muldiv;
  logic mem_wait;
  logic timeout_hit;

  assign is_alu_reg  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_imm      = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign is_mem      = (op == OP_LD) || (op == OP_ST);
  assign is_muldiv   = (op == OP_MUL) || (op == OP_DIV);
  assign mem_wait    = (state == S_F1) || ((state == S_T6) && (op == OP_LD)) ||
                       ((state == S_T7) && (op == OP_ST));
  // Ready on the last allowed wait cycle still wins over the timeout.
  assign timeout_hit = mem_wait && !in_mem_ready &&
                       (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  assign out_error = error_q;

  // State register, memory wait counter and sticky error flag
  always_ff @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state    <= S_CLEAR;
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      state   <= next_state;
      error_q <= error_q | set_error;
      if (mem_wait && !in_mem_ready) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Next-state selection: fetch sequence, opcode dispatch and memory waits
  always_comb begin
    next_state = state;
    set_error  = 1'b0;
    case (state)
      S_CLEAR: next_state = S_IDLE;
      S_IDLE:  if (in_run) next_state = S_F0;
      S_F0:    next_state = S_F1;
      S_F1: begin
        if (in_mem_ready) begin
          next_state = S_F2;
        end else if (timeout_hit) begin
          next_state = S_HALT;
          set_error  = 1'b1;
        end
      end
      S_F2: next_state = S_T3;
      S_T3: begin
        if (is_alu_reg || is_imm || is_mem || is_muldiv || (op == OP_LDI)) begin
          next_state = S_T4;
        end else if ((op == OP_JR) || (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_NOP)) begin
          next_state = S_F0;
        end else if (op == OP_HALT) begin
          next_state = S_HALT;
        end else begin
          next_state = S_HALT;
          set_error  = 1'b1;
        end
      end
      S_T4: next_state = S_T5;
      S_T5: next_state = (is_mem || is_muldiv) ? S_T6 : S_F0;
      S_T6: begin
        if (op == OP_LD) begin
          if (in_mem_ready) begin
            next_state = S_T7;
          end else if (timeout_hit) begin
            next_state = S_HALT;
            set_error  = 1'b1;
          end
        end else if (op == OP_ST) begin
          next_state = S_T7;
        end else begin
          next_state = S_F0;
        end
      end
      S_T7: begin
        if (op == OP_ST) begin
          if (in_mem_ready) begin
            next_state = S_F0;
          end else if (timeout_hit) begin
            next_state = S_HALT;
            set_error  = 1'b1;
          end
        end else begin
          next_state = S_F0;
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_HALT;
    endcase
  end

  // Output decode from the current state and the IR fields
  always_comb begin
    out_reg_clear   = 1'b0;
    out_bus_sel     = '0;
    out_wr_en       = '0;
    out_regfile_loc = '0;
    out_alu_opcode  = ALU_ADD;
    out_inc_pc      = 1'b0;
    out_mdr_select  = 1'b0;
    out_mem_read    = 1'b0;
    out_mem_write   = 1'b0;
    out_halted      = 1'b0;
    case (state)
      S_CLEAR: out_reg_clear = 1'b1;
      S_F0: begin
        out_bus_sel[BUS_PC] = 1'b1;
        out_wr_en[WR_MAR]   = 1'b1;
        out_wr_en[WR_PC]    = 1'b1;
        out_inc_pc          = 1'b1;
      end
      S_F1: begin
        out_mem_read      = 1'b1;
        out_mdr_select    = 1'b1;
        out_wr_en[WR_MDR] = in_mem_ready;
      end
      S_F2: begin
        out_bus_sel[BUS_MDR] = 1'b1;
        out_wr_en[WR_IR]     = 1'b1;
      end
      S_T3: begin
        if (is_alu_reg || is_imm || is_mem || (op == OP_LDI)) begin
          out_bus_sel[BUS_RF] = 1'b1;
          out_regfile_loc     = rb;
          out_wr_en[WR_Y]     = 1'b1;
        end else if (is_muldiv) begin
          out_bus_sel[BUS_RF] = 1'b1;
          out_regfile_loc     = ra;
          out_wr_en[WR_Y]     = 1'b1;
        end else if (op == OP_JR) begin
          out_bus_sel[BUS_RF] = 1'b1;
          out_regfile_loc     = ra;
          out_wr_en[WR_PC]    = 1'b1;
        end else if (op == OP_MFHI) begin
          out_bus_sel[BUS_HI] = 1'b1;
          out_regfile_loc     = ra;
          out_wr_en[WR_RF]    = 1'b1;
        end else if (op == OP_MFLO) begin
          out_bus_sel[BUS_LO] = 1'b1;
          out_regfile_loc     = ra;
          out_wr_en[WR_RF]    = 1'b1;
        end
      end
      S_T4: begin
        out_wr_en[WR_Z] = 1'b1;
        if (is_alu_reg) begin
          out_bus_sel[BUS_RF] = 1'b1;
          out_regfile_loc     = rc;
        end else if (is_muldiv) begin
          out_bus_sel[BUS_RF] = 1'b1;
          out_regfile_loc     = rb;
        end else begin
          out_bus_sel[BUS_C] = 1'b1;
        end
        case (op)
          OP_SUB:           out_alu_opcode = ALU_SUB;
          OP_AND, OP_ANDI:  out_alu_opcode = ALU_AND;
          OP_OR, OP_ORI:    out_alu_opcode = ALU_OR;
          OP_MUL:           out_alu_opcode = ALU_MUL;
          OP_DIV:           out_alu_opcode = ALU_DIV;
          default:          out_alu_opcode = ALU_ADD;
        endcase
      end
      S_T5: begin
        out_bus_sel[BUS_ZLO] = 1'b1;
        if (is_mem) begin
          out_wr_en[WR_MAR] = 1'b1;
        end else if (is_muldiv) begin
          out_wr_en[WR_LO] = 1'b1;
        end else begin
          out_wr_en[WR_RF] = 1'b1;
          out_regfile_loc  = ra;
        end
      end
      S_T6: begin
        if (op == OP_LD) begin
          out_mem_read      = 1'b1;
          out_mdr_select    = 1'b1;
          out_wr_en[WR_MDR] = in_mem_ready;
        end else if (op == OP_ST) begin
          out_bus_sel[BUS_RF] = 1'b1;
          out_regfile_loc     = ra;
          out_wr_en[WR_MDR]   = 1'b1;
        end else if (is_muldiv) begin
          out_bus_sel[BUS_ZHI] = 1'b1;
          out_wr_en[WR_HI]     = 1'b1;
        end
      end
      S_T7: begin
        if (op == OP_LD) begin
          out_bus_sel[BUS_MDR] = 1'b1;
          out_regfile_loc      = ra;
          out_wr_en[WR_RF]     = 1'b1;
        end else if (op == OP_ST) begin
          out_mem_write = 1'b1;
        end
      end
      S_HALT:  out_halted = 1'b1;
      default: out_halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Testbench for control_unit_fsm.
// A step-table model of each instruction's micro-operations runs beside the DUT
// and is compared every cycle; directed sequences add literal spot checks.
module tb_control_unit_fsm;

  localparam int TO = 64;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011;
  localparam logic [4:0] SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110, ADDI = 5'b01100;
  localparam logic [4:0] ANDI = 5'b01101, ORI = 5'b01110, MUL = 5'b01111, DIV = 5'b10000;
  localparam logic [4:0] JR = 5'b10100, MFHI = 5'b11000, MFLO = 5'b11001, NOP = 5'b11010;
  localparam logic [4:0] HALT = 5'b11011;

  localparam logic [8:0] B_RF = 9'h001, B_HI = 9'h002, B_LO = 9'h004, B_ZHI = 9'h008;
  localparam logic [8:0] B_ZLO = 9'h010, B_PC = 9'h020, B_MDR = 9'h040, B_C = 9'h100;
  localparam logic [8:0] W_RF = 9'h001, W_HI = 9'h002, W_LO = 9'h004, W_Z = 9'h008;
  localparam logic [8:0] W_PC = 9'h010, W_MDR = 9'h020, W_IR = 9'h040, W_Y = 9'h080;
  localparam logic [8:0] W_MAR = 9'h100;

  logic        clk = 1'b0;
  logic        in_rst_n;
  logic        in_run;
  logic [31:0] in_ir;
  logic        in_mem_ready;
  logic        out_reg_clear;
  logic [8:0]  out_bus_sel;
  logic [8:0]  out_wr_en;
  logic [3:0]  out_regfile_loc;
  logic [3:0]  out_alu_opcode;
  logic        out_inc_pc;
  logic        out_mdr_select;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_halted;
  logic        out_error;

  int checks;
  int errors;
  logic cmp_en;

  always #5 clk = ~clk;

  control_unit_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk             (clk),
    .in_rst_n        (in_rst_n),
    .in_run          (in_run),
    .in_ir           (in_ir),
    .in_mem_ready    (in_mem_ready),
    .out_reg_clear   (out_reg_clear),
    .out_bus_sel     (out_bus_sel),
    .out_wr_en       (out_wr_en),
    .out_regfile_loc (out_regfile_loc),
    .out_alu_opcode  (out_alu_opcode),
    .out_inc_pc      (out_inc_pc),
    .out_mdr_select  (out_mdr_select),
    .out_mem_read    (out_mem_read),
    .out_mem_write   (out_mem_write),
    .out_halted      (out_halted),
    .out_error       (out_error)
  );

  // One micro-operation step of an instruction; endk: 0 back to fetch, 1 halt, 2 halt with error
  typedef struct packed {
    logic [8:0] bus;
    logic [8:0] wr;
    logic [8:0] wr_rdy;
    logic [3:0] loc;
    logic [3:0] alu;
    logic       inc;
    logic       msel;
    logic       rd;
    logic       wrm;
    logic       wt;
    logic       last;
    logic [1:0] endk;
  } step_t;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc,
                                      input logic [14:0] c);
    return {op, ra, rb, rc, c};
  endfunction

  // The micro-operation table: fetch steps followed by the per-opcode execute steps
  function automatic step_t get_step(input logic [31:0] ir, input int k);
    step_t s [8];
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int n;
    logic [1:0] endk;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    for (int i = 0; i < 8; i++) s[i] = '0;
    s[0].bus = B_PC; s[0].wr = W_MAR | W_PC; s[0].inc = 1'b1;
    s[1].rd = 1'b1; s[1].msel = 1'b1; s[1].wt = 1'b1; s[1].wr_rdy = W_MDR;
    s[2].bus = B_MDR; s[2].wr = W_IR;
    n = 4; endk = 2'd0;
    case (op)
      ADD, SUB, AND_, OR_, ADDI, ANDI, ORI, LDI, LD, ST: begin
        s[3].bus = B_RF; s[3].loc = rb; s[3].wr = W_Y;
        s[4].wr = W_Z;
        if (op == ADD || op == SUB || op == AND_ || op == OR_) begin
          s[4].bus = B_RF; s[4].loc = rc;
        end else begin
          s[4].bus = B_C;
        end
        s[4].alu = (op == SUB) ? 4'd1 : (op == AND_ || op == ANDI) ? 4'd2 :
                   (op == OR_ || op == ORI) ? 4'd3 : 4'd0;
        s[5].bus = B_ZLO;
        if (op == LD) begin
          s[5].wr = W_MAR;
          s[6].rd = 1'b1; s[6].msel = 1'b1; s[6].wt = 1'b1; s[6].wr_rdy = W_MDR;
          s[7].bus = B_MDR; s[7].wr = W_RF; s[7].loc = ra;
          n = 8;
        end else if (op == ST) begin
          s[5].wr = W_MAR;
          s[6].bus = B_RF; s[6].loc = ra; s[6].wr = W_MDR;
          s[7].wrm = 1'b1; s[7].wt = 1'b1;
          n = 8;
        end else begin
          s[5].wr = W_RF; s[5].loc = ra;
          n = 6;
        end
      end
      MUL, DIV: begin
        s[3].bus = B_RF; s[3].loc = ra; s[3].wr = W_Y;
        s[4].bus = B_RF; s[4].loc = rb; s[4].wr = W_Z; s[4].alu = (op == MUL) ? 4'd4 : 4'd5;
        s[5].bus = B_ZLO; s[5].wr = W_LO;
        s[6].bus = B_ZHI; s[6].wr = W_HI;
        n = 7;
      end
      JR:   begin s[3].bus = B_RF; s[3].loc = ra; s[3].wr = W_PC; end
      MFHI: begin s[3].bus = B_HI; s[3].loc = ra; s[3].wr = W_RF; end
      MFLO: begin s[3].bus = B_LO; s[3].loc = ra; s[3].wr = W_RF; end
      NOP:  endk = 2'd0;
      HALT: endk = 2'd1;
      default: endk = 2'd2;
    endcase
    s[n-1].last = 1'b1;
    s[n-1].endk = endk;
    if (k < 0 || k > 7) return '0;
    return s[k];
  endfunction

  typedef enum int {M_CLR, M_IDLE, M_RUN, M_HALT} mmode_t;
  mmode_t m_mode;
  int     m_k;
  int     m_cnt;
  logic   m_err;
  step_t  m_cur;

  assign m_cur = get_step(in_ir, m_k);

  // Model progress: walk the step table, stretching wait steps until ready or timeout
  always @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      m_mode <= M_CLR;
      m_k    <= 0;
      m_cnt  <= 0;
      m_err  <= 1'b0;
    end else begin
      case (m_mode)
        M_CLR:  m_mode <= M_IDLE;
        M_IDLE: if (in_run) begin m_mode <= M_RUN; m_k <= 0; end
        M_RUN: begin
          if (m_cur.wt && !in_mem_ready) begin
            if (m_cnt + 1 >= TO) begin
              m_mode <= M_HALT;
              m_err  <= 1'b1;
            end else begin
              m_cnt <= m_cnt + 1;
            end
          end else begin
            m_cnt <= 0;
            if (m_cur.last) begin
              if (m_cur.endk == 2'd0) begin
                m_k <= 0;
              end else begin
                m_mode <= M_HALT;
                if (m_cur.endk == 2'd2) m_err <= 1'b1;
              end
            end else begin
              m_k <= m_k + 1;
            end
          end
        end
        default: m_mode <= m_mode;
      endcase
    end
  end

  logic [8:0] e_bus, e_wr;
  logic [3:0] e_loc, e_alu;
  logic       e_clear, e_inc, e_msel, e_rd, e_wrm, e_halted;

  // Expected outputs from the model position and current inputs
  always_comb begin
    e_clear = (m_mode == M_CLR);
    e_halted = (m_mode == M_HALT);
    e_bus = '0; e_wr = '0; e_loc = '0; e_alu = '0;
    e_inc = 1'b0; e_msel = 1'b0; e_rd = 1'b0; e_wrm = 1'b0;
    if (m_mode == M_RUN) begin
      e_bus  = m_cur.bus;
      e_wr   = m_cur.wr | (in_mem_ready ? m_cur.wr_rdy : 9'h000);
      e_loc  = m_cur.loc;
      e_alu  = m_cur.alu;
      e_inc  = m_cur.inc;
      e_msel = m_cur.msel;
      e_rd   = m_cur.rd;
      e_wrm  = m_cur.wrm;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic [31:0] ir, input logic ready);
    in_run = run;
    in_ir = ir;
    in_mem_ready = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_clear", out_reg_clear, e_clear);
      checkOutput("cyc_bus", out_bus_sel, e_bus);
      checkOutput("cyc_wr", out_wr_en, e_wr);
      checkOutput("cyc_loc", out_regfile_loc, e_loc);
      checkOutput("cyc_alu", out_alu_opcode, e_alu);
      checkOutput("cyc_inc", out_inc_pc, e_inc);
      checkOutput("cyc_msel", out_mdr_select, e_msel);
      checkOutput("cyc_rd", out_mem_read, e_rd);
      checkOutput("cyc_wrm", out_mem_write, e_wrm);
      checkOutput("cyc_halted", out_halted, e_halted);
      checkOutput("cyc_error", out_error, m_err);
      checkOutput("cyc_bus_onehot", $onehot0(out_bus_sel), 1);
      checkOutput("cyc_rd_wr_excl", out_mem_read & out_mem_write, 0);
    end
  end

  logic [31:0] tbl_ir [13];
  int          tbl_len [13];

  task automatic resetAndIdle();
    in_rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rst_clear", out_reg_clear, 1);
    checkOutput("rst_error", out_error, 0);
    tick();
    in_rst_n = 1'b1;
    tick();
    checkOutput("idle_clear", out_reg_clear, 0);
  endtask

  initial begin
    int ticks;
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    in_rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_clear", out_reg_clear, 1);
    checkOutput("rst_bus", out_bus_sel, 0);
    checkOutput("rst_wr", out_wr_en, 0);
    checkOutput("rst_rd", out_mem_read, 0);
    checkOutput("rst_halted", out_halted, 0);
    cmp_en = 1'b1;
    in_rst_n = 1'b1;
    tick();
    checkOutput("idle_clear", out_reg_clear, 0);

    $display("[TB] add r1,r2,r3 with F1 ready on third cycle");
    applyStimulus(1'b1, enc(ADD, 4'd1, 4'd2, 4'd3, 15'd0), 1'b0);
    tick();
    in_run = 1'b0;
    checkOutput("f0_bus", out_bus_sel, 9'h020);
    checkOutput("f0_wr", out_wr_en, 9'h110);
    checkOutput("f0_inc", out_inc_pc, 1);
    tick();
    checkOutput("f1_wait_wr", out_wr_en, 0);
    checkOutput("f1_read", out_mem_read, 1);
    tick();
    tick();
    in_mem_ready = 1'b1;
    #1;
    checkOutput("f1_ready_wr", out_wr_en, 9'h020);
    checkOutput("f1_msel", out_mdr_select, 1);
    tick();
    in_mem_ready = 1'b0;
    checkOutput("f2_bus", out_bus_sel, 9'h040);
    checkOutput("f2_read_dropped", out_mem_read, 0);
    tick();
    checkOutput("add_t3_loc", out_regfile_loc, 2);
    tick();
    checkOutput("add_t4_loc", out_regfile_loc, 3);
    tick();
    checkOutput("add_t5_wr", out_wr_en, 9'h001);
    checkOutput("add_t5_loc", out_regfile_loc, 1);
    checkOutput("add_t5_bus", out_bus_sel, 9'h010);
    tick();
    checkOutput("add_next_f0", out_wr_en, 9'h110);

    $display("[TB] ld r4,0x10(r5) with immediate ready");
    applyStimulus(1'b0, enc(LD, 4'd4, 4'd5, 4'd0, 15'h10), 1'b1);
    tick(); tick(); tick();
    checkOutput("ld_t3_loc", out_regfile_loc, 5);
    tick();
    checkOutput("ld_t4_bus", out_bus_sel, 9'h100);
    tick();
    checkOutput("ld_t5_wr", out_wr_en, 9'h100);
    tick();
    checkOutput("ld_t6_rd", out_mem_read, 1);
    checkOutput("ld_t6_msel", out_mdr_select, 1);
    tick();
    checkOutput("ld_t7_bus", out_bus_sel, 9'h040);
    checkOutput("ld_t7_loc", out_regfile_loc, 4);
    checkOutput("ld_t7_wr", out_wr_en, 9'h001);
    tick();

    $display("[TB] mul r2,r3");
    applyStimulus(1'b0, enc(MUL, 4'd2, 4'd3, 4'd0, 15'd0), 1'b1);
    tick(); tick(); tick(); tick();
    checkOutput("mul_t4_alu", out_alu_opcode, 4);
    tick();
    checkOutput("mul_t5_bus", out_bus_sel, 9'h010);
    checkOutput("mul_t5_wr", out_wr_en, 9'h004);
    tick();
    checkOutput("mul_t6_bus", out_bus_sel, 9'h008);
    checkOutput("mul_t6_wr", out_wr_en, 9'h002);
    tick();
    checkOutput("mul_next_f0", out_bus_sel, 9'h020);

    tbl_ir[0]  = enc(SUB, 4'd6, 4'd7, 4'd8, 15'd0);    tbl_len[0]  = 6;
    tbl_ir[1]  = enc(AND_, 4'd9, 4'd10, 4'd11, 15'd0); tbl_len[1]  = 6;
    tbl_ir[2]  = enc(OR_, 4'd12, 4'd13, 4'd14, 15'd0); tbl_len[2]  = 6;
    tbl_ir[3]  = enc(ADDI, 4'd3, 4'd2, 4'd0, 15'h7);   tbl_len[3]  = 6;
    tbl_ir[4]  = enc(ANDI, 4'd5, 4'd6, 4'd0, 15'h3);   tbl_len[4]  = 6;
    tbl_ir[5]  = enc(ORI, 4'd7, 4'd8, 4'd0, 15'h1);    tbl_len[5]  = 6;
    tbl_ir[6]  = enc(LDI, 4'd15, 4'd0, 4'd0, 15'h55);  tbl_len[6]  = 6;
    tbl_ir[7]  = enc(DIV, 4'd4, 4'd9, 4'd0, 15'd0);    tbl_len[7]  = 7;
    tbl_ir[8]  = enc(JR, 4'd11, 4'd0, 4'd0, 15'd0);    tbl_len[8]  = 4;
    tbl_ir[9]  = enc(MFHI, 4'd6, 4'd0, 4'd0, 15'd0);   tbl_len[9]  = 4;
    tbl_ir[10] = enc(MFLO, 4'd8, 4'd0, 4'd0, 15'd0);   tbl_len[10] = 4;
    tbl_ir[11] = enc(NOP, 4'd0, 4'd0, 4'd0, 15'd0);    tbl_len[11] = 4;
    tbl_ir[12] = enc(ST, 4'd3, 4'd4, 4'd0, 15'h20);    tbl_len[12] = 8;
    $display("[TB] remaining instruction classes with ready held high");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b0, tbl_ir[i], 1'b1);
      ticks = 0;
      do begin
        tick();
        ticks++;
      end while (out_wr_en != 9'h110 && ticks < 20);
      checkOutput($sformatf("len_op%0d", i), ticks, tbl_len[i]);
    end

    $display("[TB] F1 ready on the last allowed wait cycle");
    applyStimulus(1'b0, enc(NOP, 4'd0, 4'd0, 4'd0, 15'd0), 1'b0);
    tick();
    repeat (TO - 1) tick();
    in_mem_ready = 1'b1;
    #1;
    checkOutput("edge_not_halted", out_halted, 0);
    checkOutput("edge_read", out_mem_read, 1);
    tick();
    checkOutput("edge_f2_bus", out_bus_sel, 9'h040);
    checkOutput("edge_f2_halted", out_halted, 0);
    tick(); tick();

    $display("[TB] st with memory write timeout");
    applyStimulus(1'b0, enc(ST, 4'd3, 4'd4, 4'd0, 15'h8), 1'b1);
    tick(); tick();
    in_mem_ready = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    checkOutput("st_t7_wrm", out_mem_write, 1);
    checkOutput("st_t7_rd", out_mem_read, 0);
    repeat (TO - 1) tick();
    checkOutput("st_last_wait_wrm", out_mem_write, 1);
    checkOutput("st_last_wait_halted", out_halted, 0);
    tick();
    checkOutput("st_to_halted", out_halted, 1);
    checkOutput("st_to_error", out_error, 1);
    checkOutput("st_to_wrm", out_mem_write, 0);
    checkOutput("st_to_wr", out_wr_en, 0);

    $display("[TB] illegal opcode then in_run toggling");
    resetAndIdle();
    applyStimulus(1'b1, {5'b11111, 27'h0}, 1'b1);
    tick();
    in_run = 1'b0;
    tick(); tick(); tick(); tick();
    checkOutput("ill_halted", out_halted, 1);
    checkOutput("ill_error", out_error, 1);
    for (int i = 0; i < 6; i++) begin
      in_run = i[0];
      tick();
    end
    checkOutput("ill_still_halted", out_halted, 1);
    checkOutput("ill_still_error", out_error, 1);
    checkOutput("ill_bus", out_bus_sel, 0);

    $display("[TB] halt instruction");
    resetAndIdle();
    applyStimulus(1'b1, enc(HALT, 4'd0, 4'd0, 4'd0, 15'd0), 1'b1);
    tick();
    in_run = 1'b0;
    tick(); tick(); tick(); tick();
    checkOutput("halt_halted", out_halted, 1);
    checkOutput("halt_error", out_error, 0);

    $display("[TB] reset asserted during F1");
    resetAndIdle();
    applyStimulus(1'b1, enc(ADD, 4'd1, 4'd2, 4'd3, 15'd0), 1'b0);
    tick();
    in_run = 1'b0;
    tick();
    checkOutput("mid_f1_read", out_mem_read, 1);
    #2;
    in_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_clear", out_reg_clear, 1);
    checkOutput("mid_rst_read", out_mem_read, 0);
    checkOutput("mid_rst_msel", out_mdr_select, 0);
    checkOutput("mid_rst_bus", out_bus_sel, 0);
    checkOutput("mid_rst_wr", out_wr_en, 0);
    checkOutput("mid_rst_halted", out_halted, 0);
    tick();
    in_rst_n = 1'b1;
    #1;
    checkOutput("post_rst_clear", out_reg_clear, 1);
    tick();
    checkOutput("post_rst_idle", out_reg_clear, 0);
    checkOutput("post_rst_idle_bus", out_bus_sel, 0);
    tick();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
